// File: rtl/bcd_7seg_scan_driver.sv
// bcd_7seg_scan_driver: time-multiplexed, double-buffered driver for a
// DIGITS-wide common-anode 7-segment display. All display outputs are active-low.
// Optional build macro BCD7SEG_LZB_EN enables leading-zero blanking.
//
// state | meaning
// DARK  | enable=0, prescaler/index held at 0, all anodes/segments off
// SCAN  | enable=1, digits scanned one slot of REFRESH_DIV cycles each
module bcd_7seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {DARK, SCAN} state_t;

  state_t              state_q, state_nx;
  logic [PW-1:0]       presc_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] pend_bcd, active_bcd;
  logic [DIGITS-1:0]   pend_dp, active_dp;
  logic                scan, wrap;
  logic [3:0]          cur_bcd;
  logic                cur_dp, blank;
  logic [6:0]          seg_nx;
  logic                dp_nx;
  logic [DIGITS-1:0]   an_nx;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Next-state logic; enable takes effect on the very next edge
  always_comb begin
    state_nx = state_q;
    case (state_q)
      DARK:    if (enable)  state_nx = SCAN;
      SCAN:    if (!enable) state_nx = DARK;
      default: state_nx = DARK;
    endcase
  end

  assign scan = (state_nx == SCAN);
  assign wrap = scan && (presc_q == PRESC_TC) && (idx_q == IDX_LAST);

  // Select the current digit and build the next registered display outputs
  always_comb begin
    cur_bcd = 4'd0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_bcd = active_bcd[4*i +: 4];
        cur_dp  = active_dp[i];
      end
    end
`ifdef BCD7SEG_LZB_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      blank    = 1'b0;
      // digit 0 is never part of the zero run, so a lone 0 always shows
      for (int i = DIGITS - 1; i > 0; i--) begin
        zero_run = zero_run & (active_bcd[4*i +: 4] == 4'd0);
        if ((idx_q == IW'(i)) && zero_run) blank = 1'b1;
      end
    end
`else
    blank = 1'b0;
`endif
    seg_nx = (scan && !blank) ? decode(cur_bcd) : 7'h7F;
    dp_nx  = !(scan && cur_dp);
    // first cycle of each slot keeps every anode off (ghosting dead time)
    for (int i = 0; i < DIGITS; i++)
      an_nx[i] = !(scan && (presc_q != '0) && (idx_q == IW'(i)));
  end

  // State, scan counters, double-buffered banks and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DARK;
      presc_q    <= '0;
      idx_q      <= '0;
      pend_bcd   <= '0;
      pend_dp    <= '0;
      active_bcd <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
    end else begin
      state_q <= state_nx;
      if (scan) begin
        if (presc_q == PRESC_TC) begin
          presc_q <= '0;
          idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end else begin
        presc_q <= '0;
        idx_q   <= '0;
      end
      frame_tick <= wrap;
      // a load on the boundary cycle is newest and bypasses the pend bank
      if (wrap && load) begin
        active_bcd <= bcd_in;
        active_dp  <= dp_in;
        pending    <= 1'b0;
      end else if (wrap && pending) begin
        active_bcd <= pend_bcd;
        active_dp  <= pend_dp;
        pending    <= 1'b0;
      end else if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end
      seg <= seg_nx;
      dp  <= dp_nx;
      an  <= an_nx;
    end
  end

endmodule
